// File: rtl/exe_div.sv
// ----------------------------------------------------------------------------
// exe_div -- iterative RV32M divider for the execute stage.
//
// Radix-2 restoring divider working on operand magnitudes, one quotient bit
// per clock. Divide-by-zero and signed overflow are answered directly without
// iterating. The exe stage stalls on busy_o and writes back on ready_o.
//
// Ports
//   clk_i        in   1   clock, rising edge
//   rst_i        in   1   asynchronous active-high reset
//   start_i      in   1   request, sampled only while idle
//   op_i         in   2   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i   in  32   rs1 value
//   divisor_i    in  32   rs2 value
//   reg_waddr_i  in   5   destination register
//   cancel_i     in   1   pipeline flush, aborts any operation in progress
//   busy_o       out  1   operation accepted and not yet completed
//   ready_o      out  1   one-cycle pulse, result_o / reg_waddr_o valid
//   result_o     out 32   quotient or remainder
//   reg_waddr_o  out  5   latched destination register
// ----------------------------------------------------------------------------
module exe_div (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        cancel_i,
    output logic        busy_o,
    output logic        ready_o,
    output logic [31:0] result_o,
    output logic [4:0]  reg_waddr_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;      // {remainder, quotient} shift register
    logic [31:0] dvsr_q, dvsr_d;    // divisor magnitude
    logic        rem_q, rem_d;      // latched op selects remainder
    logic        negq_q, negq_d;    // quotient must be negated
    logic        negr_q, negr_d;    // remainder must be negated
    logic [31:0] res_q, res_d;      // result of the op currently in DONE
    logic [31:0] out_q, out_d;      // last delivered result
    logic [4:0]  waddr_q, waddr_d;

    // Decoded view of the incoming request.
    logic        in_signed, in_rem, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    // One restoring step. The 33-bit window acc[63:31] is the shifted partial
    // remainder including the bit that falls out of a plain 32-bit shift.
    function automatic logic [63:0] div_step(input logic [63:0] acc,
                                             input logic [31:0] dvsr);
        logic [32:0] trial;
        trial = acc[63:31] - {1'b0, dvsr};
        if (!trial[32])
            return {trial[31:0], acc[30:0], 1'b1};
        else
            return {acc[62:0], 1'b0};
    endfunction

    function automatic logic [31:0] finalize(input logic [63:0] acc,
                                             input logic        is_rem,
                                             input logic        neg_q,
                                             input logic        neg_r);
        logic [31:0] q;
        logic [31:0] r;
        q = acc[31:0];
        r = acc[63:32];
        if (is_rem)
            return neg_r ? -r : r;
        else
            return neg_q ? -q : q;
    endfunction

    always_comb begin
        in_signed = ~op_i[0];
        in_rem    = op_i[1];
        a_neg     = in_signed & dividend_i[31];
        b_neg     = in_signed & divisor_i[31];
        a_mag     = a_neg ? -dividend_i : dividend_i;
        b_mag     = b_neg ? -divisor_i : divisor_i;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvsr_d  = dvsr_q;
        rem_d   = rem_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        res_d   = res_q;
        out_d   = out_q;
        waddr_d = waddr_q;

        case (state_q)
            IDLE: begin
                if (start_i && !cancel_i) begin
                    waddr_d = reg_waddr_i;
                    rem_d   = in_rem;
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    dvsr_d  = b_mag;
                    acc_d   = {32'd0, a_mag};
                    cnt_d   = 6'd0;
                    if (divisor_i == 32'd0) begin
                        res_d   = in_rem ? dividend_i : 32'hFFFF_FFFF;
                        state_d = DONE;
                    end else if (in_signed && dividend_i == 32'h8000_0000 &&
                                 divisor_i == 32'hFFFF_FFFF) begin
                        res_d   = in_rem ? 32'd0 : 32'h8000_0000;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (cancel_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = div_step(acc_q, dvsr_q);
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        res_d   = finalize(acc_d, rem_q, negq_q, negr_q);
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // A flush during DONE suppresses delivery of this result.
                if (!cancel_i)
                    out_d = res_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            acc_q   <= 64'd0;
            dvsr_q  <= 32'd0;
            rem_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            res_q   <= 32'd0;
            out_q   <= 32'd0;
            waddr_q <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvsr_q  <= dvsr_d;
            rem_q   <= rem_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            res_q   <= res_d;
            out_q   <= out_d;
            waddr_q <= waddr_d;
        end
    end

    // ready_o is gated by cancel_i so a flush arriving in DONE kills the pulse
    // in that same cycle; result_o then keeps showing the previous result.
    assign busy_o      = (state_q != IDLE);
    assign ready_o     = (state_q == DONE) && !cancel_i;
    assign result_o    = ready_o ? res_q : out_q;
    assign reg_waddr_o = waddr_q;

endmodule

// File: doc/exe_div.md
EXE_DIV -- requirements
Module: exe_div

Interface
REQ-001 Parameters: none; operand width fixed at 32 bits, register address width fixed at 5 bits.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 start_i  in  1  request from exe stage; sampled only when busy_o low.
REQ-005 op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M semantics).
REQ-006 dividend_i  in  32  rs1 value; sampled with start_i.
REQ-007 divisor_i  in  32  rs2 value; sampled with start_i.
REQ-008 reg_waddr_i  in  5  destination register; sampled with start_i.
REQ-009 cancel_i  in  1  pipeline flush (jump); aborts any operation in progress.
REQ-010 busy_o  out  1  high while an accepted operation has not completed; exe stage drives stallreq from it.
REQ-011 ready_o  out  1  one-cycle pulse; result_o and reg_waddr_o valid.
REQ-012 result_o  out  32  quotient or remainder per latched op.
REQ-013 reg_waddr_o  out  5  latched destination register.

Function
REQ-014 The FSM shall have exactly three states: IDLE, CALC, DONE; busy_o = (state != IDLE).
REQ-015 IDLE: start_i=1 and cancel_i=0 shall latch op, operands, reg_waddr, and move to CALC, or to DONE for special cases (REQ-020, REQ-021).
REQ-016 CALC shall run a radix-2 restoring divide on operand magnitudes, one quotient bit per cycle, 32 iterations via a 6-bit counter, then move to DONE.
REQ-017 Normal latency: start_i sampled at edge E0; busy_o high cycles 1..33; ready_o high in cycle 33 only; IDLE in cycle 34.
REQ-018 DONE shall assert ready_o for exactly one cycle, then return to IDLE.
REQ-019 Signed ops: magnitudes used internally; quotient negated when operand signs differ; remainder takes dividend's sign.
REQ-020 Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = dividend; CALC skipped; ready_o in cycle 1.
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0; CALC skipped; ready_o in cycle 1.
REQ-022 result_o and reg_waddr_o shall hold their last values after ready_o until the next accepted start.
REQ-023 start_i while busy_o high shall be ignored, with no effect on state or latched values.
REQ-024 cancel_i in CALC or DONE: next state IDLE, no ready_o pulse, result_o unchanged.
REQ-025 cancel_i and start_i in the same IDLE cycle: cancel wins and the start is dropped.
REQ-026 start_i accepted in the cycle right after DONE (back-to-back) shall behave identically to an isolated start.
REQ-027 Arithmetic: 64-bit {remainder, quotient} shift register; 33-bit subtract for the trial step; no width truncation of the remainder before the final result.

Reset
REQ-028 rst_i high shall force state IDLE, counter 0, busy_o 0, ready_o 0, result_o 0, reg_waddr_o 0, and all latched operands 0 immediately, regardless of clock.
REQ-029 Reset mid-CALC shall abort with no ready_o pulse; first start after rst_i deasserts shall follow REQ-017.

Verification
REQ-030 DIVU 100/7, rd=5 -> ready_o in cycle 33 only, result_o=14, reg_waddr_o=5; REMU same operands -> 2.
REQ-031 DIV 0xFFFFFFF9 (-7) / 2 -> result_o 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIV 7 / 0xFFFFFFFE -> 0xFFFFFFFD.
REQ-032 DIVU 7/0 -> ready_o in cycle 1, result_o 0xFFFFFFFF; REMU 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-033 start in cycle 0, cancel_i in cycle 10 -> busy_o low in cycle 11, no ready_o; new start in cycle 11 completes in cycle 44.
REQ-034 start_i held high through an operation -> exactly one ready_o per accepted op, ops back-to-back with no lost or duplicate results.
REQ-035 rst_i pulsed asynchronously mid-CALC -> all outputs 0 before the next clock edge; no ready_o afterwards until a new start.
